// File: rtl/ucb_float_codec_pipe_if.sv
// Handshake and data bundle for the recoded/IEEE float codec pipeline.
// The master drives the input side and consumes results; the slave is the codec.
interface ucb_float_codec_pipe_if #(
  parameter int EXP_W = 12,
  parameter int SIG_W = 52,
  parameter int TAG_W = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_mode;
  logic [EXP_W+SIG_W:0]   in_data;
  logic [TAG_W-1:0]       in_tag;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_mode;
  logic [EXP_W+SIG_W:0]   out_data;
  logic [4:0]             out_class;
  logic [TAG_W-1:0]       out_tag;

  modport master (
    output in_valid, in_mode, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_mode, out_data, out_class, out_tag
  );

  modport slave (
    input  in_valid, in_mode, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_mode, out_data, out_class, out_tag
  );
endinterface

// File: rtl/ucb_float_codec_pipe.sv
// Two-stage codec between recoded floats (EXP_W-bit exponent) and IEEE floats.
// S1 classifies and computes the shift count, S2 shifts and assembles the result.
module ucb_float_codec_pipe #(
  parameter int EXP_W = 12,
  parameter int SIG_W = 52,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  ucb_float_codec_pipe_if.slave bus
);

  localparam int W      = EXP_W + SIG_W + 1;
  localparam int LZ_W   = $clog2(SIG_W + 1) + 1;
  localparam int CNT_W  = (EXP_W + 1 > LZ_W) ? EXP_W + 1 : LZ_W;
  localparam int B_INT  = (1 << (EXP_W - 2)) + 1;
  localparam logic [EXP_W-1:0] B   = EXP_W'(B_INT);
  localparam logic [CNT_W-1:0] B_C = CNT_W'(B_INT);

  localparam logic [4:0] C_NAN  = 5'b10000;
  localparam logic [4:0] C_INF  = 5'b01000;
  localparam logic [4:0] C_NORM = 5'b00100;
  localparam logic [4:0] C_SUB  = 5'b00010;
  localparam logic [4:0] C_ZERO = 5'b00001;

  logic               s1_valid_q, s1_valid_d;
  logic               s1_mode_q;
  logic [TAG_W-1:0]   s1_tag_q;
  logic               s1_sign_q, s1_sign_d;
  logic [EXP_W-1:0]   s1_exp_q, s1_exp_d;
  logic [SIG_W-1:0]   s1_fract_q;
  logic [4:0]         s1_cls_q, s1_cls_d;
  logic [CNT_W-1:0]   s1_cnt_q, s1_cnt_d;

  logic               s2_valid_q, s2_valid_d;
  logic               out_mode_q;
  logic [W-1:0]       out_data_q, asm_data;
  logic [4:0]         out_class_q;
  logic [TAG_W-1:0]   out_tag_q;

  logic               s2_en, s1_load, s2_load;
  logic [EXP_W-2:0]   enc_exp;
  logic [EXP_W-1:0]   rec_exp;
  logic [SIG_W-1:0]   in_fract;
  logic [2:0]         t;
  logic [CNT_W-1:0]   lz;

  logic [SIG_W-1:0]   dec_sub_fract, enc_sub_fract;
  logic [EXP_W-2:0]   dec_norm_exp;
  logic [EXP_W-1:0]   enc_norm_exp, enc_sub_exp;

  assign s2_en        = !s2_valid_q || bus.out_ready;
  assign bus.in_ready = reset || !s1_valid_q || s2_en;
  assign s1_load      = bus.in_valid && bus.in_ready && !reset;
  assign s2_load      = s2_en && s1_valid_q;
  assign s1_valid_d   = bus.in_ready ? bus.in_valid : s1_valid_q;
  assign s2_valid_d   = s2_en ? s1_valid_q : s2_valid_q;

  always_comb begin
    enc_exp  = bus.in_data[EXP_W+SIG_W-2:SIG_W];
    rec_exp  = bus.in_data[W-2:SIG_W];
    in_fract = bus.in_data[SIG_W-1:0];
    t        = rec_exp[EXP_W-1:EXP_W-3];
    lz       = '0;
    // Highest set bit wins, so lz ends as the leading-zero count.
    for (int i = 0; i < SIG_W; i++) begin
      if (in_fract[i]) lz = CNT_W'(SIG_W - 1 - i);
    end
    s1_sign_d = bus.in_data[W-1];
    s1_exp_d  = rec_exp;
    s1_cls_d  = C_NORM;
    s1_cnt_d  = B_C + CNT_W'(1) - {{(CNT_W-EXP_W){1'b0}}, rec_exp};
    if (bus.in_mode) begin
      s1_sign_d = bus.in_data[W-2];
      s1_exp_d  = {1'b0, enc_exp};
      s1_cnt_d  = lz;
      if (enc_exp == '0)
        s1_cls_d = (in_fract == '0) ? C_ZERO : C_SUB;
      else if (&enc_exp)
        s1_cls_d = (in_fract == '0) ? C_INF : C_NAN;
      else
        s1_cls_d = C_NORM;
    end else begin
      if (t == 3'b000)
        s1_cls_d = C_ZERO;
      else if (t == 3'b001 || (t[2:1] == 2'b01 && rec_exp <= B))
        s1_cls_d = C_SUB;
      else if (t == 3'b110)
        s1_cls_d = C_INF;
      else if (t == 3'b111)
        s1_cls_d = C_NAN;
      else
        s1_cls_d = C_NORM;
    end
  end

  // Oversized right shifts fall off naturally, giving a zero fraction.
  assign dec_sub_fract = SIG_W'({1'b1, s1_fract_q} >> s1_cnt_q);
  assign dec_norm_exp  = (EXP_W-1)'(s1_exp_q - B);
  assign enc_sub_fract = s1_fract_q << (s1_cnt_q + CNT_W'(1));
  assign enc_sub_exp   = EXP_W'(B_C - s1_cnt_q);
  assign enc_norm_exp  = s1_exp_q + B;

  always_comb begin
    asm_data = '0;
    if (s1_mode_q) begin
      case (s1_cls_q)
        C_ZERO:  asm_data = {s1_sign_q, {EXP_W{1'b0}}, {SIG_W{1'b0}}};
        C_SUB:   asm_data = {s1_sign_q, enc_sub_exp, enc_sub_fract};
        C_INF:   asm_data = {s1_sign_q, 3'b110, {(EXP_W-3){1'b0}}, {SIG_W{1'b0}}};
        C_NAN:   asm_data = {s1_sign_q, 3'b111, {(EXP_W-3){1'b0}}, s1_fract_q};
        default: asm_data = {s1_sign_q, enc_norm_exp, s1_fract_q};
      endcase
    end else begin
      case (s1_cls_q)
        C_ZERO:  asm_data = {1'b0, s1_sign_q, {(EXP_W-1){1'b0}}, {SIG_W{1'b0}}};
        C_SUB:   asm_data = {1'b0, s1_sign_q, {(EXP_W-1){1'b0}}, dec_sub_fract};
        C_INF:   asm_data = {1'b0, s1_sign_q, {(EXP_W-1){1'b1}}, {SIG_W{1'b0}}};
        C_NAN:   asm_data = {1'b0, s1_sign_q, {(EXP_W-1){1'b1}}, s1_fract_q};
        default: asm_data = {1'b0, s1_sign_q, dec_norm_exp, s1_fract_q};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
    if (s1_load) begin
      s1_mode_q  <= bus.in_mode;
      s1_tag_q   <= bus.in_tag;
      s1_sign_q  <= s1_sign_d;
      s1_exp_q   <= s1_exp_d;
      s1_fract_q <= in_fract;
      s1_cls_q   <= s1_cls_d;
      s1_cnt_q   <= s1_cnt_d;
    end
    if (s2_load) begin
      out_mode_q  <= s1_mode_q;
      out_data_q  <= asm_data;
      out_class_q <= s1_cls_q;
      out_tag_q   <= s1_tag_q;
    end
  end

  assign bus.out_valid = s2_valid_q && !reset;
  assign bus.out_mode  = out_mode_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_class = out_class_q;
  assign bus.out_tag   = out_tag_q;

endmodule

// File: doc/ucb_float_codec_pipe.md
UCB_FLOAT_CODEC_PIPE -- requirements
Module: ucb_float_codec_pipe

Interface
REQ-001 Parameter EXP_W, default 12, recoded exponent width; the IEEE exponent width is EXP_W-1; legal range 4..16.
REQ-002 Parameter SIG_W, default 52, fraction width excluding the hidden bit; legal range 2..112.
REQ-003 Parameter TAG_W, default 4, width of the sideband tag carried alongside each transaction.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port in_valid, input, 1 bit: an input transaction is offered.
REQ-007 Port in_ready, output, 1 bit: the block accepts the offered transaction this cycle.
REQ-008 Port in_mode, input, 1 bit: 0 = decode (recoded to IEEE), 1 = encode (IEEE to recoded).
REQ-009 Port in_data, input, EXP_W+SIG_W+1 bits: a recoded operand in decode mode, or an IEEE operand in bits [EXP_W+SIG_W-1:0] in encode mode with the MSB ignored.
REQ-010 Port in_tag, input, TAG_W bits: sideband tag, returned unchanged with the result.
REQ-011 Port out_valid, output, 1 bit: a result is presented.
REQ-012 Port out_ready, input, 1 bit: the consumer accepts the presented result.
REQ-013 Port out_mode, output, 1 bit: in_mode of the presented result.
REQ-014 Port out_data, output, EXP_W+SIG_W+1 bits: in decode mode, the IEEE value in the low bits with the MSB forced to 0; in encode mode, the recoded value.
REQ-015 Port out_class, output, 5 bits, one-hot {nan, inf, normal, subnormal, zero} (bit 4 to bit 0): class of the operand.
REQ-016 Port out_tag, output, TAG_W bits: in_tag of the presented result.

Function
REQ-017 The block SHALL be a 2-stage pipeline (S1 classify/count, S2 shift/assemble) with a latency of 2 cycles from acceptance to out_valid when there is no stall, and a throughput of 1 per cycle.
REQ-018 A transfer SHALL occur when valid && ready on either side; in_ready = !S1_valid || !S2_valid || out_ready.
REQ-019 When out_valid && !out_ready, S2 SHALL hold out_data, out_class, out_mode and out_tag stable, and S1 SHALL advance only if S2 is empty.
REQ-020 Decode classification SHALL use B = 2^(EXP_W-2)+1 and the top three recoded exponent bits t: t=000 is zero; t=001 is subnormal; t=01x with recExp<=B is subnormal; B<recExp<3*2^(EXP_W-2) is normal; t=110 is inf; t=111 is NaN.
REQ-021 Decode normal SHALL give IEEE exp = (recExp - B) truncated to EXP_W-1 bits, with the fraction copied.
REQ-022 Decode subnormal SHALL give exp = 0 and fraction = low SIG_W bits of ({1,fract} >> (B+1-recExp)), with shift distances >= SIG_W+1 yielding 0.
REQ-023 Decode inf SHALL give exp all-ones and fraction 0; decode NaN SHALL give exp all-ones with the fraction copied; decode zero SHALL give exp 0 and fraction 0; the sign is always copied.
REQ-024 Encode classification SHALL follow IEEE: exp 0 with fraction 0 is zero; exp 0 with nonzero fraction is subnormal; exp all-ones with fraction 0 is inf; exp all-ones with nonzero fraction is NaN; anything else is normal.
REQ-025 Encode normal SHALL give recExp = ieeeExp + B, with the fraction copied.
REQ-026 Encode subnormal SHALL compute lz = leading-zero count of the fraction in S1, then give recExp = B - lz and fraction = low SIG_W bits of (fract << (lz+1)) in S2.
REQ-027 Encode zero SHALL give recExp 0 and fraction 0; encode inf SHALL give t=110 with the remaining exponent bits 0 and fraction 0; encode NaN SHALL give t=111 with the remaining exponent bits 0 and the fraction copied; the sign is always copied.
REQ-028 All arithmetic SHALL be unsigned with explicit widths; there are no X-dependent or wildcard compares.
REQ-029 Mixed-mode back-to-back transactions SHALL complete in order with no bubbles.

Reset
REQ-030 While reset is high, S1_valid, S2_valid and out_valid SHALL be 0 and in_ready SHALL be 1; data registers may hold any value.
REQ-031 A reset asserted mid-stream SHALL discard all in-flight transactions, with no output of them after reset deasserts.
REQ-032 A transaction offered in the same cycle as reset SHALL NOT be accepted.

Verification
REQ-033 Decode of 65'h0_8000000000000000 (defaults) -> 2 cycles later out_data 65'h0_3FF0000000000000 and out_class 5'b00100.
REQ-034 Encode of 64'h0000000000000001 -> out_data 65'h0_3CE0000000000000 and class subnormal; decoding that result returns 64'h0000000000000001.
REQ-035 Encode of 64'h7FF8000000000000 -> 65'h0_E008000000000000 and class NaN; decode of 65'h0_C000000000000000 -> 64'h7FF0000000000000 and class inf.
REQ-036 Decode of 65'h1_0000000000000000 -> 64'h8000000000000000 and class zero.
REQ-037 Hold out_ready low for 5 cycles while streaming 4 transactions with tags 0..3 -> in_ready drops after 2 are buffered; outputs stay stable during the stall; the results emerge in tag order 0,1,2,3 with none lost or duplicated.
REQ-038 Assert reset for 1 cycle with 2 transactions in flight -> out_valid stays 0 until a new transaction is accepted.
